// File: rtl/nbank_frame_buffer.sv
// N-bank frame capture/replay buffer between STFT and MEL_FBANK; drops whole frames on overrun.
// Optional macro NBANK_BITREV_RD_EN: replay a bit-reversed FFT frame in natural bin order.
module nbank_frame_buffer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 257,
  parameter int N_BANKS = 2,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BANK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [ADDR_W-1:0] data_out_idx,
  output logic              data_out_last,
  output logic              overflow,
  output logic [BANK_W:0]   frames_pending
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);

  if (N_BANKS < 2) begin : g_bad_banks
    $error("nbank_frame_buffer: N_BANKS must be at least 2");
  end

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    next_bank = (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

`ifdef NBANK_BITREV_RD_EN
  localparam int RB = $clog2(DEPTH - 1);

  if ((1 << RB) != (DEPTH - 1)) begin : g_bad_depth
    $error("nbank_frame_buffer: DEPTH-1 must be a power of two for bit-reversed reads");
  end

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    bitrev = '0;
    for (int i = 0; i < RB; i++) bitrev[i] = a[RB-1-i];
  endfunction
`endif

  logic [WIDTH-1:0]   r_mem [N_BANKS][DEPTH];

  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [BANK_W-1:0]  r_wr_bank;
  logic               r_dropping;
  logic               r_overflow;
  logic [N_BANKS-1:0] r_full;
  logic [BANK_W:0]    r_pending;

  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [BANK_W-1:0]  r_rd_bank;
  logic               r_fetch_done;

  logic [WIDTH-1:0]   r_data_p1;
  logic [ADDR_W-1:0]  r_idx_p1;
  logic               r_last_p1;
  logic               r_vld_p1;
  logic [WIDTH-1:0]   r_data_p2;
  logic [ADDR_W-1:0]  r_idx_p2;
  logic               r_last_p2;
  logic               r_vld_p2;

  logic               w_release;
  logic               w_wr_first;
  logic               w_wr_last;
  logic               w_drop;
  logic               w_wr_en;
  logic               w_set;
  logic               w_move_p1;
  logic               w_load_p2;
  logic               w_fetch;
  logic               w_fetch_last;
  logic [ADDR_W-1:0]  w_rd_addr;

  // A bank whose last word leaves this cycle counts as free for a frame starting now.
  assign w_release  = r_vld_p2 & data_out_ready & r_last_p2;
  assign w_wr_first = (r_wr_ptr == '0);
  assign w_wr_last  = (r_wr_ptr == LAST_IDX);
  assign w_drop     = r_dropping |
                      (w_wr_first & r_full[r_wr_bank] &
                       ~(w_release & (r_rd_bank == r_wr_bank)));
  assign w_wr_en    = data_valid & ~w_drop;
  assign w_set      = w_wr_en & w_wr_last;

  assign w_load_p2    = ~r_vld_p2 | data_out_ready;
  assign w_move_p1    = r_vld_p1 & w_load_p2;
  assign w_fetch      = r_full[r_rd_bank] & ~r_fetch_done & (~r_vld_p1 | w_move_p1);
  assign w_fetch_last = (r_rd_ptr == LAST_IDX);

`ifdef NBANK_BITREV_RD_EN
  assign w_rd_addr = w_fetch_last ? r_rd_ptr : bitrev(r_rd_ptr);
`else
  assign w_rd_addr = r_rd_ptr;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_bank][r_wr_ptr] <= data_in;
    // stage p1: synchronous memory read
    if (w_fetch) r_data_p1 <= r_mem[r_rd_bank][w_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_wr_bank  <= '0;
      r_dropping <= 1'b0;
      r_overflow <= 1'b0;
    end else if (sync_clr) begin
      r_wr_ptr   <= '0;
      r_wr_bank  <= '0;
      r_dropping <= 1'b0;
      r_overflow <= 1'b0;
    end else if (data_valid) begin
      r_wr_ptr   <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
      r_dropping <= w_drop & ~w_wr_last;
      if (w_drop) r_overflow <= 1'b1;
      if (w_set)  r_wr_bank  <= next_bank(r_wr_bank);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_pending <= '0;
    end else if (sync_clr) begin
      r_full    <= '0;
      r_pending <= '0;
    end else begin
      if (w_release) r_full[r_rd_bank] <= 1'b0;
      if (w_set)     r_full[r_wr_bank] <= 1'b1;
      if (w_set && !w_release)      r_pending <= r_pending + 1'b1;
      else if (!w_set && w_release) r_pending <= r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_rd_bank    <= '0;
      r_fetch_done <= 1'b0;
    end else if (sync_clr) begin
      r_rd_ptr     <= '0;
      r_rd_bank    <= '0;
      r_fetch_done <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_rd_ptr <= w_fetch_last ? '0 : r_rd_ptr + 1'b1;
        if (w_fetch_last) r_fetch_done <= 1'b1;
      end
      if (w_release) begin
        r_fetch_done <= 1'b0;
        r_rd_bank    <= next_bank(r_rd_bank);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_idx_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else if (sync_clr) begin
      r_vld_p1  <= 1'b0;
      r_idx_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else if (w_fetch) begin
      r_vld_p1  <= 1'b1;
      r_idx_p1  <= r_rd_ptr;
      r_last_p1 <= w_fetch_last;
    end else if (w_move_p1) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // stage p2: output register, holds while valid and not ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_idx_p2  <= '0;
      r_last_p2 <= 1'b0;
    end else if (sync_clr) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_idx_p2  <= '0;
      r_last_p2 <= 1'b0;
    end else if (w_load_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= r_data_p1;
        r_idx_p2  <= r_idx_p1;
        r_last_p2 <= r_last_p1;
      end
    end
  end

  assign data_out       = r_data_p2;
  assign data_out_valid = r_vld_p2;
  assign data_out_idx   = r_idx_p2;
  assign data_out_last  = r_last_p2;
  assign overflow       = r_overflow;
  assign frames_pending = r_pending;

endmodule

// File: tb/tb_nbank_frame_buffer.sv
// Bench for nbank_frame_buffer (DEPTH=5, N_BANKS=2) against a frame-queue reference model.
`timescale 1ns/1ps
module tb_nbank_frame_buffer;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 5;
  localparam int N_BANKS = 2;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int BANK_W  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              sync_clr;
  logic [WIDTH-1:0]  data_in;
  logic              data_valid;
  logic [WIDTH-1:0]  data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [ADDR_W-1:0] data_out_idx;
  logic              data_out_last;
  logic              overflow;
  logic [BANK_W:0]   frames_pending;

  always #5 clk = ~clk;

  nbank_frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_BANKS(N_BANKS)) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .data_in(data_in), .data_valid(data_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_idx(data_out_idx), .data_out_last(data_out_last), .overflow(overflow),
    .frames_pending(frames_pending)
  );

  typedef struct packed {
    logic [WIDTH-1:0]  d;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } word_t;

  word_t            exp_q[$];
  word_t            obs_q[$];
  logic [WIDTH-1:0] m_frame[$];
  int               m_wcnt, m_rcnt, m_pend;
  bit               m_drop, m_ovf;
  int               errors = 0;
  int               checks = 0;
  int               stab_err = 0;
  bit               hold_prev;
  word_t            hold_w;

  // Output position k of a frame shows the k-th written word, or its bit-reversed partner.
  function automatic int src_of(input int k);
    int r;
    r = k;
`ifdef NBANK_BITREV_RD_EN
    if (k != DEPTH - 1) begin
      r = 0;
      for (int i = 0; i < $clog2(DEPTH - 1); i++)
        if (((k >> i) & 1) != 0) r = r | (1 << ($clog2(DEPTH - 1) - 1 - i));
    end
`endif
    return r;
  endfunction

  task automatic m_reset();
    exp_q.delete(); obs_q.delete(); m_frame.delete();
    m_wcnt = 0; m_rcnt = 0; m_pend = 0; m_drop = 0; m_ovf = 0; hold_prev = 0;
  endtask

  // One clock: drive inputs, record transfers, advance the model, return at the next negedge.
  task automatic step(input bit dv, input logic [WIDTH-1:0] din, input bit rdy, input bit clr);
    word_t w;
    bit    rel;
    data_valid = dv; data_in = din; data_out_ready = rdy; sync_clr = clr;
    w = {data_out, data_out_idx, data_out_last};
    if (hold_prev && (!data_out_valid || w !== hold_w)) stab_err++;
    hold_prev = data_out_valid && !rdy && !clr;
    hold_w = w;
    rel = 0;
    if (clr) m_reset();
    else begin
      if (data_out_valid && rdy) begin
        obs_q.push_back(w);
        m_rcnt++;
        if (m_rcnt == DEPTH) begin m_rcnt = 0; rel = 1; m_pend--; end
      end
      if (dv) begin
        if (m_wcnt == 0) begin
          m_drop = (m_pend == N_BANKS) && !rel;
          if (m_drop) m_ovf = 1;
        end
        if (!m_drop) m_frame.push_back(din);
        m_wcnt++;
        if (m_wcnt == DEPTH) begin
          m_wcnt = 0;
          if (!m_drop) begin
            for (int k = 0; k < DEPTH; k++)
              exp_q.push_back({m_frame[src_of(k)], ADDR_W'(k), (k == DEPTH - 1)});
            m_frame.delete();
            m_pend++;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && !(m_pend == 0 && !data_out_valid); i++) step(0, '0, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; sync_clr = 1'b0; data_valid = 1'b0; data_in = '0; data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", data_out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data: got %0d want 0", data_out); end
    checks++; if (data_out_idx !== '0) begin errors++; $display("FAIL rst_idx: got %0d want 0", data_out_idx); end
    checks++; if (data_out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", data_out_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (frames_pending !== '0) begin errors++; $display("FAIL rst_pending: got %0d want 0", frames_pending); end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_single_frame();
    int n;
    for (int k = 1; k <= DEPTH; k++) step(1, WIDTH'(k), 1, 0);
    checks++; if (frames_pending !== 2'd1) begin errors++; $display("FAIL t1_pending_set: got %0d want 1", frames_pending); end
    n = 0;
    while (!data_out_valid && n < 10) begin step(0, '0, 1, 0); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL t1_latency: got %0d cycles want 2", n); end
    drain();
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL t1_count: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t1_word%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b", i,
                 obs_q[i].d, obs_q[i].idx, obs_q[i].last, exp_q[i].d, exp_q[i].idx, exp_q[i].last);
      end
    end
    checks++; if (frames_pending !== '0) begin errors++; $display("FAIL t1_pending_clr: got %0d want 0", frames_pending); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overrun();
    for (int f = 1; f <= 3; f++)
      for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(f * 10 + k), 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t2_overflow: got %b want 1", overflow); end
    checks++; if (frames_pending !== 2'd2) begin errors++; $display("FAIL t2_pending: got %0d want 2", frames_pending); end
    drain();
    checks++; if (obs_q.size() != 2 * DEPTH) begin errors++; $display("FAIL t2_count: got %0d want %0d", obs_q.size(), 2 * DEPTH); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t2_word%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b", i,
                 obs_q[i].d, obs_q[i].idx, obs_q[i].last, exp_q[i].d, exp_q[i].idx, exp_q[i].last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_release_same_cycle();
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int f = 1; f <= 2; f++)
      for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(f * 10 + k), 0, 0);
    n = 0;
    while (!(data_out_valid && data_out_last) && n < 40) begin step(0, '0, 1, 0); n++; end
    checks++; if (n >= 40) begin errors++; $display("FAIL t3_wait_last: got timeout after %0d cycles want last word", n); end
    for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(30 + k), 1, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_overflow: got %b want 0", overflow); end
    drain();
    checks++; if (obs_q.size() != 3 * DEPTH) begin errors++; $display("FAIL t3_count: got %0d want %0d", obs_q.size(), 3 * DEPTH); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t3_word%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b", i,
                 obs_q[i].d, obs_q[i].idx, obs_q[i].last, exp_q[i].d, exp_q[i].idx, exp_q[i].last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_ready();
    int  written;
    int  cyc;
    bit  dv;
    written = 0;
    cyc = 0;
    while (written < 4 * DEPTH && cyc < 500) begin
      dv = ($urandom_range(0, 3) != 0);
      step(dv, WIDTH'($urandom), bit'($urandom % 2), 0);
      if (dv) written++;
      cyc++;
      checks++;
      if (frames_pending !== (BANK_W + 1)'(m_pend)) begin
        errors++; $display("FAIL t4_pending_c%0d: got %0d want %0d", cyc, frames_pending, m_pend);
      end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL t4_overflow_c%0d: got %b want %b", cyc, overflow, m_ovf); end
    end
    drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t4_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t4_word%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b", i,
                 obs_q[i].d, obs_q[i].idx, obs_q[i].last, exp_q[i].d, exp_q[i].idx, exp_q[i].last);
      end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL t4_stall_stable: got %0d violations want 0", stab_err); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sync_clr();
    for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(40 + k), 0, 0);
    for (int k = 0; k < 3; k++) step(1, WIDTH'(50 + k), 0, 0);
    step(0, '0, 0, 1);
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b want 0", data_out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL t5_data: got %0d want 0", data_out); end
    checks++; if (frames_pending !== '0) begin errors++; $display("FAIL t5_pending: got %0d want 0", frames_pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_overflow: got %b want 0", overflow); end
    for (int k = 0; k < DEPTH; k++) step(1, WIDTH'(60 + k), 1, 0);
    drain();
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL t5_count: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t5_word%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d last=%b", i,
                 obs_q[i].d, obs_q[i].idx, obs_q[i].last, exp_q[i].d, exp_q[i].idx, exp_q[i].last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_release_same_cycle();
    test_random_ready();
    test_sync_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nbank_frame_buffer.md
Name: nbank_frame_buffer

Overview:
- Parametrised N-bank successor to the two-bank power-spectrum frame buffer between STFT and MEL_FBANK.
- Captures fixed-length frames of bins from a non-stallable producer into N_BANKS banks of DEPTH words each.
- Replays complete frames in order through a valid/ready output, with bin index and last-bin markers.
- Detects and flags frame overruns instead of corrupting banks that have not yet drained.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 257, words per frame (N_FFT/2+1).
- N_BANKS, 2, number of frame banks; minimum 2.
- ADDR_W, $clog2(DEPTH), bin index width (derived).
- BANK_W, (N_BANKS>1 ? $clog2(N_BANKS) : 1), bank pointer width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- sync_clr  in  1  synchronous flush of all banks, pointers and flags.
- data_in  in  WIDTH  input bin.
- data_valid  in  1  input strobe; no backpressure to the producer.
- data_out  out  WIDTH  output bin.
- data_out_valid  out  1  data_out holds a valid word.
- data_out_ready  in  1  consumer accepts the word.
- data_out_idx  out  ADDR_W  bin index of data_out (0..DEPTH-1).
- data_out_last  out  1  data_out is bin DEPTH-1.
- overflow  out  1  sticky: at least one frame was dropped.
- frames_pending  out  BANK_W+1  number of full banks not yet fully read.

Behaviour:
- Reset (rst=1, async): all pointers, counters and full flags = 0; data_out_valid=0; data_out=0; data_out_idx=0; data_out_last=0; overflow=0; frames_pending=0.
- sync_clr has the same effect, synchronously, and has priority over all other activity in that cycle.
- Write side:
  - wr_ptr counts 0..DEPTH-1; wr_bank is the current bank.
  - Each data_valid cycle writes mem[wr_bank][wr_ptr] and increments wr_ptr.
  - When wr_ptr = DEPTH-1 is written: full[wr_bank] is set, wr_ptr wraps to 0, and wr_bank advances modulo N_BANKS.
- Overrun:
  - At the first word of a frame (wr_ptr=0), if full[wr_bank]=1 and that bank is not being released in the same cycle, the whole frame is dropped.
  - DEPTH data_valid strobes are counted but not stored; wr_bank does not advance; overflow is set.
  - A release in the same cycle counts as free: the frame is accepted.
- Read side:
  - Memory is read synchronously with 1-cycle latency, followed by one output register (skid: 2-entry).
  - When full[rd_bank]=1, words are fetched at addresses 0..DEPTH-1.
  - Fetching advances whenever the output pipeline has space; no bubbles while data_out_ready stays high.
  - The transfer of the last word (valid&ready with data_out_last) clears full[rd_bank] and advances rd_bank modulo N_BANKS.
- Latency: bank full flag set at edge T (last write) -> first data_out_valid at T+2.
- Handshake: data_out, data_out_idx and data_out_last stay stable while valid & !ready; valid never drops without a transfer.
- frames_pending changes by +1 on set, -1 on release, and is unchanged when both occur in the same cycle.
- Writing and reading different banks in the same cycle are independent; the same bank is never read and written at once (guaranteed by the full flags).

Optional Feature:
- Macro: NBANK_BITREV_RD_EN.
- Defined:
  - Read addresses are bit-reversed over $clog2(DEPTH-1) bits for idx < DEPTH-1, so a bit-reversed FFT output is presented in natural order.
  - The final word (idx DEPTH-1, Nyquist) is read unreversed.
  - data_out_idx reports the natural (output-order) index.
  - Elaboration error if DEPTH-1 is not a power of two.
- Undefined: linear addressing.

Test Plan (WIDTH=16, DEPTH=5, N_BANKS=2 unless noted):
- Reset then write frame 1..5 with ready=1 -> outputs 1,2,3,4,5 with idx 0..4, last on 5, first valid 2 cycles after the 5th write, frames_pending 1->0.
- Write frames A (10..14), B (20..24), C (30..34) back to back with ready=0 -> C dropped, overflow=1, frames_pending=2. Then ready=1 -> A then B out, no C.
- Write frame C so that its first word arrives in the same cycle as A's last read transfer -> C accepted, overflow stays 0.
- Random ready toggling over 4 frames -> no word lost, duplicated or changed while stalled; idx and last stay consistent.
- sync_clr mid-frame (after 3 writes, while one frame is pending) -> next cycle data_out_valid=0, frames_pending=0, overflow=0; the next 5 writes form a clean frame.
- With NBANK_BITREV_RD_EN, mem loaded 0..4 -> outputs mem[0],mem[2],mem[1],mem[3],mem[4] with idx 0..4.
